// File: rtl/light_seq_pkg.sv
// Shared types and constants for the Red Light / Green Light phase sequencer.
package light_seq_pkg;

  // Light phase; IDLE means no game is running.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GREEN = 2'd1,
    ST_WARN  = 2'd2,
    ST_RED   = 2'd3
  } state_t;

  // Width and saturation point of the completed-round counter.
  localparam int          ROUND_W   = 8;
  localparam logic [7:0]  ROUND_MAX = 8'd255;

  // Bit offset of the RED duration field inside the LFSR word.
  localparam int          RED_FIELD_OFS = 8;

  // Observability bundle: current phase plus the two timers' key conditions.
  typedef struct packed {
    state_t state;
    logic   phase_zero;
    logic   grace_expire;
  } seq_dbg_t;

endpackage

// File: rtl/light_sequencer_phase_timer.sv
// Loadable down-counter. Load wins over tick; the count parks at zero.
// expire flags the tick that takes the count from 1 to 0.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] cnt,
  output logic         expire
);

  // Count register: load, else decrement on tick while non-zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = tick && (cnt == W'(1));

endmodule

// File: rtl/light_sequencer.sv
// Red Light / Green Light phase sequencer: GREEN -> WARN -> RED -> GREEN with
// LFSR-randomised GREEN and RED lengths, a grace window at the start of RED,
// and a saturating count of completed RED phases.
// Handshake note: there is no valid/ready flow here; start is a one-cycle
// request honoured only in IDLE, stop is a level that wins over everything,
// and tick is a one-cycle timebase enable.
module light_sequencer
  import light_seq_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter int MIN_GREEN       = 4,
  parameter int GREEN_RAND_BITS = 3,
  parameter int MIN_RED         = 3,
  parameter int RED_RAND_BITS   = 3,
  parameter int WARN_TICKS      = 2,
  parameter int GRACE_TICKS     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        rnd,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  output logic               green,
  output logic               warn,
  output logic               red,
  output logic               red_onset,
  output logic               check_en,
  output logic [ROUND_W-1:0] round_cnt,
  output seq_dbg_t           dbg
);

  localparam int GRACE_W = (GRACE_TICKS < 2) ? 2 : $clog2(GRACE_TICKS + 1);

  if (MIN_GREEN + (2 ** GREEN_RAND_BITS) - 1 >= (2 ** CNT_W)) begin : g_bad_green
    $error("light_sequencer: GREEN load range exceeds CNT_W");
  end
  if (MIN_RED + (2 ** RED_RAND_BITS) - 1 >= (2 ** CNT_W)) begin : g_bad_red
    $error("light_sequencer: RED load range exceeds CNT_W");
  end
  if (GRACE_TICKS >= MIN_RED) begin : g_bad_grace
    $error("light_sequencer: GRACE_TICKS must be below MIN_RED");
  end

  state_t             state, state_next;
  logic               phase_load, grace_load;
  logic [CNT_W-1:0]   phase_val, phase_cnt;
  logic [GRACE_W-1:0] grace_val, grace_cnt;
  logic               phase_expire, grace_expire;
  logic               clr_round, inc_round;
  logic [CNT_W-1:0]   green_len, red_len;
  logic               rnd_unused;

  // Only a handful of rnd bits feed the length fields.
  assign rnd_unused = ^rnd;

  assign green_len = CNT_W'(MIN_GREEN) + CNT_W'(rnd[GREEN_RAND_BITS-1:0]);
  assign red_len   = CNT_W'(MIN_RED)
                   + CNT_W'(rnd[RED_FIELD_OFS+RED_RAND_BITS-1:RED_FIELD_OFS]);

  phase_timer #(.W(CNT_W)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (phase_load),
    .load_val (phase_val),
    .tick     (tick),
    .cnt      (phase_cnt),
    .expire   (phase_expire)
  );

  phase_timer #(.W(GRACE_W)) u_grace (
    .clk      (clk),
    .reset    (reset),
    .load     (grace_load),
    .load_val (grace_val),
    .tick     (tick),
    .cnt      (grace_cnt),
    .expire   (grace_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and timer-load decode; stop overrides every transition.
  always_comb begin
    state_next = state;
    phase_load = 1'b0;
    phase_val  = '0;
    grace_load = 1'b0;
    grace_val  = '0;
    clr_round  = 1'b0;
    inc_round  = 1'b0;
    if (stop) begin
      state_next = ST_IDLE;
      phase_load = 1'b1;
      grace_load = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state_next = ST_GREEN;
          phase_load = 1'b1;
          phase_val  = green_len;
          clr_round  = 1'b1;
        end
        ST_GREEN: if (phase_expire) begin
          state_next = ST_WARN;
          phase_load = 1'b1;
          phase_val  = CNT_W'(WARN_TICKS);
        end
        ST_WARN: if (phase_expire) begin
          state_next = ST_RED;
          phase_load = 1'b1;
          phase_val  = red_len;
          grace_load = 1'b1;
          grace_val  = GRACE_W'(GRACE_TICKS);
        end
        ST_RED: if (phase_expire) begin
          state_next = ST_GREEN;
          phase_load = 1'b1;
          phase_val  = green_len;
          inc_round  = 1'b1;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Red-onset pulse: high for the first cycle spent in RED.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) red_onset <= 1'b0;
    else        red_onset <= (state_next == ST_RED) && (state != ST_RED);
  end

  // Completed-round counter: cleared at game start, saturates, held on stop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   round_cnt <= '0;
    else if (clr_round)                           round_cnt <= '0;
    else if (inc_round && round_cnt != ROUND_MAX) round_cnt <= round_cnt + 8'd1;
  end

  // Light and check outputs decoded straight from registered state.
  always_comb begin
    green    = (state == ST_GREEN);
    warn     = (state == ST_WARN);
    red      = (state == ST_RED);
    check_en = (state == ST_RED) && (grace_cnt == '0);
  end

  assign dbg.state        = state;
  assign dbg.phase_zero   = (phase_cnt == '0);
  assign dbg.grace_expire = grace_expire;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with default parameters.
module tb_light_sequencer;
  import light_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] rnd = 16'h0000;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        green, warn, red, red_onset, check_en;
  logic [7:0]  round_cnt;
  seq_dbg_t    dbg;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] L_OFF   = 5'b00000;
  localparam logic [4:0] L_GREEN = 5'b10000;
  localparam logic [4:0] L_WARN  = 5'b01000;
  localparam logic [4:0] L_ONSET = 5'b00110;
  localparam logic [4:0] L_RED_C = 5'b00101;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  light_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .rnd       (rnd),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .green     (green),
    .warn      (warn),
    .red       (red),
    .red_onset (red_onset),
    .check_en  (check_en),
    .round_cnt (round_cnt),
    .dbg       (dbg)
  );

  // Driver: advance one clock and settle just past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard comparison.
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_lights(input string tag, input logic [4:0] exp_l);
    chk(tag, {11'b0, green, warn, red, red_onset, check_en}, {11'b0, exp_l});
  endtask

  task automatic chk_state(input string tag, input state_t exp_s);
    chk(tag, {14'b0, dbg.state}, {14'b0, exp_s});
  endtask

  initial begin
    // Reset state
    repeat (2) cyc();
    chk_lights("reset_lights", L_OFF);
    chk("reset_round", {8'b0, round_cnt}, 16'd0);
    chk_state("reset_state", ST_IDLE);
    chk("reset_phase_zero", {15'b0, dbg.phase_zero}, 16'd1);
    reset = 1'b1;
    cyc();
    chk_state("idle_after_release", ST_IDLE);

    // Round 1: rnd=ACE1 -> GREEN 5, WARN 2, RED 7
    tick = 1'b1;
    rnd = 16'hACE1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_lights("a_green_enter", L_GREEN);
    chk("a_phase_loaded", {15'b0, dbg.phase_zero}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      rnd = 16'hFFFF;
      cyc();
      chk_lights("a_green_hold", L_GREEN);
    end
    cyc();
    chk_lights("a_warn_enter", L_WARN);
    cyc();
    chk_lights("a_warn_hold", L_WARN);
    rnd = 16'hACE1;
    cyc();
    chk_lights("a_red_onset", L_ONSET);
    chk("a_grace_expire", {15'b0, dbg.grace_expire}, 16'd1);
    rnd = 16'hFFFF;
    cyc();
    chk_lights("a_red_check", L_RED_C);
    for (int i = 0; i < 5; i++) begin
      rnd = 16'hFFFF;
      cyc();
      chk_lights("a_red_hold", L_RED_C);
    end
    rnd = 16'hACE1;
    cyc();
    chk_lights("a_green_again", L_GREEN);
    chk("a_round_one", {8'b0, round_cnt}, 16'd1);

    // Round 2, stop during the third tick of RED
    for (int i = 0; i < 4; i++) begin
      rnd = 16'hFFFF;
      cyc();
      chk_lights("b_green_hold", L_GREEN);
    end
    cyc();
    chk_lights("b_warn_enter", L_WARN);
    cyc();
    rnd = 16'hACE1;
    cyc();
    chk_lights("b_red_onset", L_ONSET);
    rnd = 16'hFFFF;
    cyc();
    chk_lights("b_red_tick1", L_RED_C);
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk_lights("b_stop_lights", L_OFF);
    chk_state("b_stop_state", ST_IDLE);
    chk("b_stop_round_held", {8'b0, round_cnt}, 16'd1);

    // Ticks in IDLE do nothing
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_lights("c_idle_tick", L_OFF);
    end

    // start together with stop stays IDLE
    start = 1'b1;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk_state("c_start_stop_state", ST_IDLE);
    chk_lights("c_start_stop_lights", L_OFF);
    chk("c_start_stop_round", {8'b0, round_cnt}, 16'd1);
    rnd = 16'hACE1;
    cyc();
    start = 1'b0;
    chk_lights("c_restart_green", L_GREEN);
    chk("c_restart_round_clr", {8'b0, round_cnt}, 16'd0);

    // Asynchronous reset while in WARN
    repeat (4) cyc();
    cyc();
    chk_lights("d_warn_enter", L_WARN);
    #2;
    reset = 1'b0;
    #1;
    chk_lights("d_async_lights", L_OFF);
    chk_state("d_async_state", ST_IDLE);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_state("d_idle_after_reset", ST_IDLE);
    end
    chk_lights("d_idle_lights", L_OFF);

    // Saturation: rnd=0 -> 4 + 2 + 3 = 9 cycles per round
    rnd = 16'h0000;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (254 * 9) cyc();
    chk("e_round_254", {8'b0, round_cnt}, 16'd254);
    repeat (9) cyc();
    chk("e_round_255", {8'b0, round_cnt}, 16'd255);
    repeat (5 * 9) cyc();
    chk("e_round_sat", {8'b0, round_cnt}, 16'd255);
    chk_lights("e_green_at_round", L_GREEN);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("e_stop_round_held", {8'b0, round_cnt}, 16'd255);

    // Sparse ticks: GREEN of 4 ticks counts ticks, not cycles
    tick = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("f_round_clr", {8'b0, round_cnt}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      chk_lights("f_green_sparse", L_GREEN);
    end
    cyc();
    chk_lights("f_green_no_tick", L_GREEN);
    tick = 1'b1;
    cyc();
    chk_lights("f_warn_enter", L_WARN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/light_sequencer.md
Name: light_sequencer

Overview:
- Consumes the 16-bit pseudo-random word from the game's LFSR.
- Runs the Red Light / Green Light phase sequence GREEN -> WARN -> RED -> GREEN with randomized GREEN and RED durations.
- Sits between the LFSR and the player-motion checker / display logic.
- Drives light indicators, a red-onset pulse, a motion-check enable (after a grace window) and a round counter.

Parameters:
- CNT_W, 8, width of the phase countdown register.
- MIN_GREEN, 4, minimum GREEN length in ticks (>=1).
- GREEN_RAND_BITS, 3, number of random bits added to GREEN length, taken from rnd[GREEN_RAND_BITS-1:0].
- MIN_RED, 3, minimum RED length in ticks (>=1).
- RED_RAND_BITS, 3, number of random bits added to RED length, taken from rnd[8+RED_RAND_BITS-1:8].
- WARN_TICKS, 2, fixed WARN length in ticks (>=1).
- GRACE_TICKS, 1, ticks at the start of RED during which motion is not checked (< MIN_RED).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rnd  in  16  LFSR output word, sampled only on phase-load cycles.
- tick  in  1  single-cycle timebase enable; all durations are counted in ticks.
- start  in  1  pulse; begins a game from IDLE.
- stop  in  1  level/pulse; game over, forces IDLE.
- green  out  1  green light on.
- warn  out  1  warning light (GREEN ending) on.
- red  out  1  red light on.
- red_onset  out  1  one-cycle pulse on the cycle the FSM enters RED.
- check_en  out  1  high in RED once the grace window has expired.
- round_cnt  out  8  count of completed RED phases, saturating at 255.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, grace=0, round_cnt=0.
  - All outputs 0.
- FSM states: IDLE, GREEN, WARN, RED, encoded as a one-hot or enum from the package. Outputs are registered: green/warn/red are high exactly when state is GREEN/WARN/RED.
- IDLE:
  - start=1 and stop=0 -> GREEN next edge.
  - Load counter = MIN_GREEN + zero-extended rnd[GREEN_RAND_BITS-1:0].
  - Clear round_cnt.
- GREEN:
  - Counter decrements on tick.
  - On an edge where tick=1 and counter==1 -> WARN; load counter = WARN_TICKS.
  - A phase loaded with N therefore lasts exactly N ticks.
- WARN: same countdown rule; on expiry -> RED, load counter = MIN_RED + zero-extended rnd[8+RED_RAND_BITS-1:8], load grace = GRACE_TICKS.
- RED entry:
  - red_onset=1 for exactly the first cycle in RED.
  - check_en=0 while grace!=0; grace decrements on tick.
  - check_en=1 from the cycle after grace reaches 0 until RED exits.
  - If GRACE_TICKS=0, check_en rises on the same cycle as red.
- RED expiry -> GREEN: reload GREEN duration from current rnd, round_cnt += 1 (holds at 255).
- Arithmetic and sampling:
  - Load sums are computed in CNT_W bits.
  - Parameters must satisfy MIN + 2^BITS - 1 < 2^CNT_W, checked by an elaboration-time assertion.
  - rnd is ignored on every cycle except load edges.
- Priority and edge cases:
  - stop beats every other input: any state -> IDLE next edge, outputs cleared, round_cnt held (not cleared) so the score stays visible.
  - start is ignored outside IDLE.
  - stop and start together in IDLE -> stay IDLE.
  - tick with counter==0 cannot occur outside IDLE; in IDLE tick is ignored.
  - Asynchronous reset mid-phase returns to IDLE immediately; no partial pulse on red_onset.

Decomposition:
- Package light_seq_pkg holds:
  - the state enum: IDLE, GREEN, WARN, RED;
  - the round_cnt width and its saturation constant (255);
  - the rnd field offset constant (8) for the RED field.
- One sub-module, phase_timer: a loadable CNT_W down-counter with inputs load, load_val, tick and output expire (tick && cnt==1).
- Instantiated twice: once for the phase countdown, once (narrow) for the grace window.

Test Plan:
- Defaults, rnd=16'hACE1, start pulse:
  - GREEN lasts 5 ticks (4+1), WARN 2 ticks.
  - RED lasts 7 ticks (3+4), red_onset a single cycle.
  - check_en rises after 1 tick of RED; round_cnt=1 on re-entry to GREEN.
- rnd changes every cycle mid-phase -> durations unchanged; only load-edge values are used (verify by forcing rnd=16'hFFFF off-load).
- stop asserted in RED at tick 3 -> IDLE next edge, all lights 0, check_en 0, round_cnt held. Then start -> round_cnt clears to 0.
- reset=0 asynchronously in WARN (between clock edges) -> outputs 0 immediately; after release, FSM stays IDLE until start.
- Force round_cnt toward saturation (run 260 rounds, rnd=0, min durations) -> round_cnt stays at 255.
- start and stop asserted together in IDLE -> remains IDLE; tick pulses in IDLE produce no output change.
